// File: rtl/btn_pkg.sv
// Shared types and helpers for the button conditioner: channel state encoding
// and the ms-tick period derived from the clock frequency.
package btn_pkg;

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} btn_state_e;

  function automatic int ms_to_cycles(input int clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, tick-based debouncer, press/hold/repeat
// state machine and registered event pulses. The ms tick comes from the top.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000,
  parameter int REPEAT_MS     = 200,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic rise_next
);

  localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_MS + 1);
  localparam int REP_W  = (REPEAT_MS > 0) ? $clog2(REPEAT_MS + 1) : 1;
  localparam int REP_TERM = (REPEAT_MS > 0) ? REPEAT_MS - 1 : 0;
  localparam logic POL = (ACTIVE_LOW != 0);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_MS - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_TERM);

  logic              sync1, sync2;
  logic              s;
  logic              accept;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [REP_W-1:0]  rep_cnt;
  btn_state_e        state;

  // Reset the synchroniser to the released polarity so s starts at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= POL;
      sync2 <= POL;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  assign s         = sync2 ^ POL;
  assign accept    = tick && (s != level) && (db_cnt == DB_LAST);
  assign rise_next = (state == IDLE) && accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt       <= '0;
      level        <= 1'b0;
      hold_cnt     <= '0;
      rep_cnt      <= '0;
      state        <= IDLE;
      rise         <= 1'b0;
      fall         <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      rise         <= 1'b0;
      fall         <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;

      if (s == level) begin
        db_cnt <= '0;
      end else if (accept) begin
        db_cnt <= '0;
        level  <= ~level;
      end else if (tick) begin
        db_cnt <= db_cnt + 1'b1;
      end

      // A debounced release takes priority over any hold/repeat tick.
      unique case (state)
        IDLE: begin
          if (accept) begin
            state    <= PRESSED;
            hold_cnt <= '0;
            rise     <= 1'b1;
          end
        end
        PRESSED: begin
          if (accept) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            fall     <= 1'b1;
          end else if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              state      <= HELD;
              hold_cnt   <= '0;
              rep_cnt    <= '0;
              long_pulse <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        HELD: begin
          if (accept) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            fall     <= 1'b1;
          end else if (tick && (REPEAT_MS > 0)) begin
            if (rep_cnt == REP_LAST) begin
              rep_cnt      <= '0;
              repeat_pulse <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button front end: a shared ms-tick prescaler feeding N_CH
// independent conditioning channels, plus a registered OR of the press pulses.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CLK_HZ        = 100_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000,
  parameter int REPEAT_MS     = 200,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] i_btn,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic [N_CH-1:0] o_long,
  output logic [N_CH-1:0] o_repeat,
  output logic            o_any
);

  localparam int TICK_CYC = ms_to_cycles(CLK_HZ);
  localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYC - 1);

  logic [PW-1:0]   pre_cnt;
  logic            tick;
  logic [N_CH-1:0] rise_next;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      o_any   <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      o_any   <= |rise_next;
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_MS  (DEBOUNCE_MS),
      .LONG_PRESS_MS(LONG_PRESS_MS),
      .REPEAT_MS    (REPEAT_MS),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .btn         (i_btn[gi]),
      .level       (o_level[gi]),
      .rise        (o_rise[gi]),
      .fall        (o_fall[gi]),
      .long_pulse  (o_long[gi]),
      .repeat_pulse(o_repeat[gi]),
      .rise_next   (rise_next[gi])
    );
  end

endmodule
